// File: rtl/trend_history_ctrl.sv
// Trend-display price history controller: circular buffer in a single-port RAM,
// pending-trade FIFO, and arbitration between scanout reads and blank-time commits.
module trend_history_ctrl #(
   parameter int DEPTH      = 640,
   parameter int AW         = 10,
   parameter int DW         = 8,
   parameter int PEND_DEPTH = 4
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          match_signal,
   input  logic [DW-1:0] trade_price,
   input  logic          video_on,
   input  logic [9:0]    h_cnt,
   input  logic [9:0]    v_cnt,
   output logic [AW-1:0] ram_addr,
   output logic          ram_we,
   output logic [DW-1:0] ram_wdata,
   input  logic [DW-1:0] ram_rdata,
   output logic [DW-1:0] pix_price,
   output logic          pix_valid,
   output logic          busy_clear,
   output logic [2:0]    pend_count,
   output logic [7:0]    drop_count
);

   localparam int PW = $clog2(PEND_DEPTH);
   localparam logic [0:0]    ST_CLEAR = 1'b0;
   localparam logic [0:0]    ST_RUN   = 1'b1;
   localparam logic [AW:0]   DEPTH_W  = (AW+1)'(DEPTH);
   localparam logic [AW-1:0] LAST     = AW'(DEPTH - 1);
   localparam logic [2:0]    FULL_CNT = 3'(PEND_DEPTH);

   logic [0:0]    state;
   logic [AW-1:0] clr_addr;
   logic [AW-1:0] wptr;
   logic [AW-1:0] addr_hold;
   logic          match_prev;
   logic          pix_valid_q;
   logic [2:0]    count_q;
   logic [7:0]    drop_q;
   logic [PW-1:0] fifo_rd;
   logic [PW-1:0] fifo_wr;
   logic [DW-1:0] fifo_mem [PEND_DEPTH];

   logic          push;
   logic          pop;
   logic          accept;
   logic          drop;
   logic          in_run;
   logic          read_sel;
   logic          write_sel;
   logic          fifo_empty;
   logic          fifo_full;
   logic [AW:0]   h_ext;
   logic [AW:0]   rd_sum;
   logic [AW:0]   rd_diff;
   logic [AW-1:0] rd_addr;

   // wptr marks the oldest entry, so column h lives at wptr+h modulo DEPTH.
   assign h_ext      = (AW+1)'(h_cnt);
   assign rd_sum     = {1'b0, wptr} + h_ext;
   assign rd_diff    = rd_sum - DEPTH_W;
   assign rd_addr    = (rd_sum >= DEPTH_W) ? rd_diff[AW-1:0] : rd_sum[AW-1:0];

   assign push       = match_signal & ~match_prev;
   assign in_run     = (state == ST_RUN);
   assign fifo_empty = (count_q == 3'd0);
   assign fifo_full  = (count_q == FULL_CNT);
   assign read_sel   = in_run && video_on && (h_ext < DEPTH_W);
   assign write_sel  = in_run && !read_sel && (v_cnt >= 10'd480) && !fifo_empty;
   assign pop        = write_sel;
   assign accept     = push && (!fifo_full || pop);
   assign drop       = push && fifo_full && !pop;

   assign pix_price  = ram_rdata;
   assign pix_valid  = pix_valid_q;
   assign busy_clear = reset | (state == ST_CLEAR);
   assign pend_count = count_q;
   assign drop_count = drop_q;

   // RAM port mux; scanout reads always beat pending commits, and an idle cycle keeps the address.
   always_comb begin
      ram_we    = 1'b0;
      ram_addr  = addr_hold;
      ram_wdata = '0;
      if (reset) begin
         ram_addr = '0;
      end else if (state == ST_CLEAR) begin
         ram_we   = 1'b1;
         ram_addr = clr_addr;
      end else if (read_sel) begin
         ram_addr = rd_addr;
      end else if (write_sel) begin
         ram_we    = 1'b1;
         ram_addr  = wptr;
         ram_wdata = fifo_mem[fifo_rd];
      end
   end

   always_ff @(posedge clk) begin
      if (accept) begin
         fifo_mem[fifo_wr] <= trade_price;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= ST_CLEAR;
         clr_addr    <= '0;
         wptr        <= '0;
         addr_hold   <= '0;
         match_prev  <= 1'b0;
         pix_valid_q <= 1'b0;
         count_q     <= 3'd0;
         drop_q      <= 8'd0;
         fifo_rd     <= '0;
         fifo_wr     <= '0;
      end else begin
         match_prev  <= match_signal;
         pix_valid_q <= read_sel;
         addr_hold   <= ram_addr;
         if (state == ST_CLEAR) begin
            if (clr_addr == LAST) begin
               clr_addr <= '0;
               state    <= ST_RUN;
            end else begin
               clr_addr <= clr_addr + 1'b1;
            end
         end
         if (pop) begin
            fifo_rd <= fifo_rd + 1'b1;
            wptr    <= (wptr == LAST) ? '0 : wptr + 1'b1;
         end
         if (accept) begin
            fifo_wr <= fifo_wr + 1'b1;
         end
         if (accept && !pop) begin
            count_q <= count_q + 3'd1;
         end else if (!accept && pop) begin
            count_q <= count_q - 3'd1;
         end
         if (drop && (drop_q != 8'hFF)) begin
            drop_q <= drop_q + 8'd1;
         end
      end
   end

endmodule

// File: doc/trend_history_ctrl.md
Name: trend_history_ctrl

Overview:
Controller and arbiter for the trend-display price history.
- Replaces the 640-entry shift register with a circular buffer in a single-port RAM (depth 640, 8-bit, 1-cycle read latency).
- Edge-detects trade matches and queues new prices in a small pending FIFO.
- Gives the RAM to VGA scanout reads during active video and commits pending writes only during vertical blanking, so a frame never tears.
- After every reset, runs a clear sweep that zeros the whole RAM.

Parameters:
DEPTH, 640, history entries (one per screen column)
AW, 10, RAM address width
DW, 8, price width
PEND_DEPTH, 4, pending-write FIFO entries (power of 2)

Ports:
clk  in  1  system clock, 50 MHz
reset  in  1  synchronous, active-high
match_signal  in  1  trade match level; each rising edge is one trade
trade_price  in  DW  price sampled on the match rising edge
video_on  in  1  VGA active-area flag
h_cnt  in  10  pixel X, 0-799
v_cnt  in  10  pixel Y, 0-524
ram_addr  out  AW  RAM address
ram_we  out  1  RAM write enable
ram_wdata  out  DW  RAM write data
ram_rdata  in  DW  RAM read data, valid 1 cycle after address
pix_price  out  DW  history price for the column read last cycle (= ram_rdata)
pix_valid  out  1  pix_price valid this cycle
busy_clear  out  1  clear sweep in progress
pend_count  out  3  pending FIFO occupancy, 0..PEND_DEPTH
drop_count  out  8  trades dropped on FIFO overflow, saturates at 255

Behaviour:
- Clock and reset: single clock clk; reset is synchronous and active-high, sampled on the clk rising edge.
- Reset (any cycle, including mid-sweep or mid-write):
  - state=CLEAR, clr_addr=0, wptr=0, FIFO flushed.
  - pend_count=0, drop_count=0, pix_valid=0, match_prev=0.
  - While reset is high: ram_we=0, ram_addr=0, ram_wdata=0, busy_clear=1.
- Edge detect:
  - match_prev registers match_signal.
  - push = match_signal & ~match_prev; it pushes trade_price into the FIFO.
  - Edges are captured in every state, including CLEAR.
- FIFO rules:
  - Push when full: that trade is dropped, FIFO unchanged, drop_count += 1 (saturating at 255).
  - Push and pop in the same cycle: both occur and occupancy is unchanged. This holds when full, so the push is not dropped.
- State CLEAR:
  - Each cycle: ram_we=1, ram_addr=clr_addr, ram_wdata=0, then clr_addr += 1.
  - The cycle that writes address DEPTH-1 goes to RUN; the sweep takes exactly 640 cycles.
  - busy_clear=1 throughout CLEAR; pix_valid=0.
- State RUN, decided each cycle by priority:
  1. Read: when video_on=1 and h_cnt<DEPTH.
     - ram_we=0.
     - ram_addr = (wptr + h_cnt) mod DEPTH, computed as an 11-bit sum minus DEPTH if the sum is ≥ DEPTH.
     - pix_valid=1 on the next cycle.
  2. Write: when v_cnt≥480 (vertical blank) and the FIFO is not empty.
     - ram_we=1, ram_addr=wptr, ram_wdata=FIFO head, pop.
     - wptr += 1, wrapping 639→0.
  3. Otherwise: ram_we=0, ram_addr holds its last value.
- Read mapping:
  - wptr always points at the oldest entry.
  - Column 0 is the oldest price; column 639 is the newest.
- Timing and latency:
  - pix_price/pix_valid lag h_cnt by exactly 1 cycle; pix_valid=0 on every cycle that follows a non-read cycle.
  - Writes never occur while v_cnt<480, so wptr is constant over the visible lines of a frame.
  - At most one write per clock. A burst of N≤PEND_DEPTH pending trades commits in N consecutive blank cycles.
- Visibility: a trade captured during visible lines appears starting with the next frame.

Test Plan:
- Clear sweep: reset 1 cycle, then release → busy_clear=1 for 640 cycles; ram_we=1 with addresses 0..639 and data 0; then RUN; pend_count=0.
- Basic write and read: 3 match pulses (prices 50, 60, 70) during v_cnt=100 → pend_count=3 and no write while v_cnt<480. At v_cnt=480, 3 consecutive writes to addresses 0, 1, 2; wptr=3. Next frame, h_cnt=639 reads address 2 and pix_price=70 one cycle later; h_cnt=0 reads address 3.
- Wrap-around: commit 641 trades total → wptr=1. Read address at h_cnt=639 is 0 (newest); at h_cnt=0 it is 1.
- Overflow: 6 match edges with no blanking → pend_count=4, drop_count=2, and the 4 oldest prices are kept. A push and pop in the same cycle while full → no drop.
- Reset mid-operation: assert reset at clear address 300 → sweep restarts at 0 and runs the full 640 cycles. Assert reset with 2 pending trades in RUN → pend_count=0, wptr=0, drop_count=0.
- Edge detect during CLEAR: match held high for 10 cycles at clear address 100 → exactly 1 push, committed at the first vertical blank after CLEAR ends.
